// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID register bypass
// and saturating stall/flush event counters for a 5-stage RISC-V pipeline.
module idex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [5:0]       id_ctrl,
    input  logic [1:0]       id_ALUOp,
    input  logic             memwb_RegWrite,
    input  logic [4:0]       memwb_rd,
    input  logic [XLEN-1:0]  memwb_wdata,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [4:0]       idex_rs1,
    output logic [4:0]       idex_rs2,
    output logic [4:0]       idex_rd,
    output logic [XLEN-1:0]  idex_rdata1,
    output logic [XLEN-1:0]  idex_rdata2,
    output logic [XLEN-1:0]  idex_imm,
    output logic [5:0]       idex_ctrl,
    output logic [1:0]       idex_ALUOp,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ALU_ITYPE = 2'b11;
    localparam int         MEMREAD_BIT = 4;

    logic haz;
    logic stall_bubble;
    logic flush_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Register file writes land at the end of this cycle, so a matching WB write wins.
    function automatic logic [XLEN-1:0] wb_bypass(input logic [4:0] rs, input logic [XLEN-1:0] rdata);
        return (memwb_RegWrite && memwb_rd != 5'd0 && memwb_rd == rs) ? memwb_wdata : rdata;
    endfunction

    // rs2 is checked for every non-I-type class, loads included, which may stall needlessly.
    always_comb begin
        haz = idex_ctrl[MEMREAD_BIT] && (idex_rd != 5'd0) &&
              ((idex_rd == id_rs1) || ((id_ALUOp != ALU_ITYPE) && (idex_rd == id_rs2)));
    end

    assign pc_write     = ~(haz & ~flush & ~hold);
    assign ifid_write   = pc_write;
    assign flush_bubble = ~hold & flush;
    assign stall_bubble = ~hold & ~flush & haz;

    always_ff @(posedge clk) begin
        if (rst || flush_bubble || stall_bubble) begin
            idex_rs1    <= '0;
            idex_rs2    <= '0;
            idex_rd     <= '0;
            idex_rdata1 <= '0;
            idex_rdata2 <= '0;
            idex_imm    <= '0;
            idex_ctrl   <= '0;
            idex_ALUOp  <= '0;
        end else if (!hold) begin
            idex_rs1    <= id_rs1;
            idex_rs2    <= id_rs2;
            idex_rd     <= id_rd;
            idex_rdata1 <= wb_bypass(id_rs1, id_rdata1);
            idex_rdata2 <= wb_bypass(id_rs2, id_rdata2);
            idex_imm    <= id_imm;
            idex_ctrl   <= id_ctrl;
            idex_ALUOp  <= id_ALUOp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_bubble) stall_cnt <= sat_inc(stall_cnt);
            if (flush_bubble) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Directed table-driven bench for idex_hazard_stage: a default-width instance plus a
// CNT_W=2 instance fed identical stimulus for counter saturation.
module tb_idex_hazard_stage;

    localparam logic [5:0] C_LW   = 6'b110110;
    localparam logic [5:0] C_ADD  = 6'b100000;
    localparam logic [5:0] C_ADDI = 6'b100010;

    typedef enum {K_LOAD, K_BUB, K_KEEP} kind_e;

    typedef struct {
        logic        rst, hold, flush;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [5:0]  ctrl;
        logic [1:0]  alu;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mwd;
    } in_t;

    typedef struct {
        in_t         i;
        logic        chk_pcw;
        logic        pcw;
        kind_e       kind;
        logic [31:0] e1, e2;
        logic [15:0] es, ef;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [5:0]  ctrl;
        logic [1:0]  alu;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst, hold, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [5:0]  id_ctrl;
    logic [1:0]  id_ALUOp;
    logic        memwb_RegWrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_wdata;

    logic        pc_write, ifid_write;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [31:0] idex_rdata1, idex_rdata2, idex_imm;
    logic [5:0]  idex_ctrl;
    logic [1:0]  idex_ALUOp;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_ifid_write;
    logic [4:0]  s_idex_rs1, s_idex_rs2, s_idex_rd;
    logic [31:0] s_idex_rdata1, s_idex_rdata2, s_idex_imm;
    logic [5:0]  s_idex_ctrl;
    logic [1:0]  s_idex_ALUOp;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int    n_pass = 0;
    int    n_total = 0;
    int    row_idx = 0;
    snap_t exp_s;
    vec_t  tbl[$];

    always #5 clk = ~clk;

    idex_hazard_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_ALUOp(id_ALUOp),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2), .idex_imm(idex_imm),
        .idex_ctrl(idex_ctrl), .idex_ALUOp(idex_ALUOp),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    idex_hazard_stage #(.XLEN(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_ALUOp(id_ALUOp),
        .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_rs1(s_idex_rs1), .idex_rs2(s_idex_rs2), .idex_rd(s_idex_rd),
        .idex_rdata1(s_idex_rdata1), .idex_rdata2(s_idex_rdata2), .idex_imm(s_idex_imm),
        .idex_ctrl(s_idex_ctrl), .idex_ALUOp(s_idex_ALUOp),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    endtask

    function automatic in_t ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                input logic [5:0] ctrl, input logic [1:0] alu);
        in_t r;
        r.rst = 1'b0; r.hold = 1'b0; r.flush = 1'b0;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.d1 = d1; r.d2 = d2; r.imm = imm;
        r.ctrl = ctrl; r.alu = alu;
        r.mwe = 1'b0; r.mrd = 5'd0; r.mwd = 32'd0;
        return r;
    endfunction

    function automatic vec_t mkv(input in_t i, input logic chk, input logic pcw, input kind_e k,
                                 input logic [31:0] e1, input logic [31:0] e2,
                                 input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.i = i; v.chk_pcw = chk; v.pcw = pcw; v.kind = k;
        v.e1 = e1; v.e2 = e2; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic apply(input in_t i);
        rst = i.rst; hold = i.hold; flush = i.flush;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        id_rdata1 = i.d1; id_rdata2 = i.d2; id_imm = i.imm;
        id_ctrl = i.ctrl; id_ALUOp = i.alu;
        memwb_RegWrite = i.mwe; memwb_rd = i.mrd; memwb_wdata = i.mwd;
    endtask

    task automatic run_row(input vec_t v);
        snap_t g, gs;
        @(negedge clk);
        apply(v.i);
        #1;
        if (v.chk_pcw) begin
            check("pc_write", row_idx, 128'(pc_write), 128'(v.pcw));
            check("ifid_write", row_idx, 128'(ifid_write), 128'(v.pcw));
            check("s_pc_write", row_idx, 128'(s_pc_write), 128'(v.pcw));
            check("s_ifid_write", row_idx, 128'(s_ifid_write), 128'(v.pcw));
        end
        @(posedge clk);
        #1;
        case (v.kind)
            K_LOAD: begin
                exp_s.rs1 = v.i.rs1; exp_s.rs2 = v.i.rs2; exp_s.rd = v.i.rd;
                exp_s.d1 = v.e1; exp_s.d2 = v.e2; exp_s.imm = v.i.imm;
                exp_s.ctrl = v.i.ctrl; exp_s.alu = v.i.alu;
            end
            K_BUB:   exp_s = '0;
            default: ;
        endcase
        g.rs1 = idex_rs1; g.rs2 = idex_rs2; g.rd = idex_rd;
        g.d1 = idex_rdata1; g.d2 = idex_rdata2; g.imm = idex_imm;
        g.ctrl = idex_ctrl; g.alu = idex_ALUOp;
        gs.rs1 = s_idex_rs1; gs.rs2 = s_idex_rs2; gs.rd = s_idex_rd;
        gs.d1 = s_idex_rdata1; gs.d2 = s_idex_rdata2; gs.imm = s_idex_imm;
        gs.ctrl = s_idex_ctrl; gs.alu = s_idex_ALUOp;
        check("idex_state", row_idx, 128'(g), 128'(exp_s));
        check("s_idex_state", row_idx, 128'(gs), 128'(exp_s));
        check("stall_cnt", row_idx, 128'(stall_cnt), 128'(v.es));
        check("flush_cnt", row_idx, 128'(flush_cnt), 128'(v.ef));
        row_idx++;
    endtask

    initial begin
        in_t  t;
        vec_t v;

        // Reset with arbitrary inputs, including hold/flush
        t = ins(5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 6'($urandom), 2'($urandom));
        t.rst = 1'b1; t.hold = 1'b1; t.mwe = 1'b1; t.mrd = 5'($urandom); t.mwd = $urandom;
        tbl.push_back(mkv(t, 1'b0, 1'b1, K_BUB, 0, 0, 0, 0));
        t = ins(5'd5, 5'd5, 5'd5, $urandom, $urandom, $urandom, C_LW, 2'b00);
        t.rst = 1'b1; t.hold = 1'b1; t.flush = 1'b1;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_BUB, 0, 0, 0, 0));
        // Load-use on rs1
        tbl.push_back(mkv(ins(5'd2, 5'd0, 5'd5, 32'h100, 0, 32'd4, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 32'h100, 0, 0, 0));
        tbl.push_back(mkv(ins(5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 0, C_ADD, 2'b10), 1'b1, 1'b0, K_BUB, 0, 0, 1, 0));
        tbl.push_back(mkv(ins(5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 0, C_ADD, 2'b10), 1'b1, 1'b1, K_LOAD, 32'h11, 32'h22, 1, 0));
        // I-type ignores rs2 field
        tbl.push_back(mkv(ins(5'd1, 5'd0, 5'd7, 32'h200, 0, 32'd8, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 32'h200, 0, 1, 0));
        tbl.push_back(mkv(ins(5'd3, 5'd7, 5'd9, 32'h33, 32'h77, 32'h10, C_ADDI, 2'b11), 1'b1, 1'b1, K_LOAD, 32'h33, 32'h77, 1, 0));
        // Load-use on rs2 for R-type
        tbl.push_back(mkv(ins(5'd1, 5'd0, 5'd7, 32'h200, 0, 32'd8, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 32'h200, 0, 1, 0));
        tbl.push_back(mkv(ins(5'd3, 5'd7, 5'd10, 32'h1, 32'h2, 0, C_ADD, 2'b10), 1'b1, 1'b0, K_BUB, 0, 0, 2, 0));
        tbl.push_back(mkv(ins(5'd3, 5'd7, 5'd10, 32'h1, 32'h2, 0, C_ADD, 2'b10), 1'b1, 1'b1, K_LOAD, 32'h1, 32'h2, 2, 0));
        // Flush together with a load-use condition
        tbl.push_back(mkv(ins(5'd0, 5'd0, 5'd5, 0, 0, 32'h20, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 0, 0, 2, 0));
        t = ins(5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 0, C_ADD, 2'b10); t.flush = 1'b1;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_BUB, 0, 0, 2, 1));
        tbl.push_back(mkv(ins(5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 0, C_ADD, 2'b10), 1'b1, 1'b1, K_LOAD, 32'h11, 32'h22, 2, 1));
        // WB bypass cases
        t = ins(5'd4, 5'd9, 5'd11, 32'h44, 0, 0, C_ADD, 2'b10); t.mwe = 1'b1; t.mrd = 5'd9; t.mwd = 32'hDEADBEEF;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_LOAD, 32'h44, 32'hDEADBEEF, 2, 1));
        t = ins(5'd9, 5'd9, 5'd12, 32'h5, 32'h6, 0, C_ADD, 2'b10); t.mwe = 1'b1; t.mrd = 5'd9; t.mwd = 32'hCAFEF00D;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_LOAD, 32'hCAFEF00D, 32'hCAFEF00D, 2, 1));
        t = ins(5'd0, 5'd0, 5'd13, 32'h12, 32'h34, 0, C_ADD, 2'b10); t.mwe = 1'b1; t.mrd = 5'd0; t.mwd = 32'hFFFFFFFF;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_LOAD, 32'h12, 32'h34, 2, 1));
        t = ins(5'd4, 5'd1, 5'd14, 32'h55, 32'h66, 0, C_ADD, 2'b10); t.mwe = 1'b0; t.mrd = 5'd4; t.mwd = 32'h99;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_LOAD, 32'h55, 32'h66, 2, 1));
        // Hold during a hazard, then release
        tbl.push_back(mkv(ins(5'd1, 5'd0, 5'd5, 32'h300, 0, 32'd12, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 32'h300, 0, 2, 1));
        t = ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10); t.hold = 1'b1;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_KEEP, 0, 0, 2, 1));
        t.flush = 1'b1;
        tbl.push_back(mkv(t, 1'b1, 1'b1, K_KEEP, 0, 0, 2, 1));
        tbl.push_back(mkv(ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10), 1'b1, 1'b0, K_BUB, 0, 0, 3, 1));
        // Reset in the middle of a stall
        tbl.push_back(mkv(ins(5'd1, 5'd0, 5'd5, 32'h300, 0, 32'd12, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 32'h300, 0, 3, 1));
        t = ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10); t.rst = 1'b1;
        tbl.push_back(mkv(t, 1'b1, 1'b0, K_BUB, 0, 0, 0, 0));
        tbl.push_back(mkv(ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10), 1'b1, 1'b1, K_LOAD, 32'h7, 32'h8, 0, 0));

        foreach (tbl[k]) run_row(tbl[k]);

        // Five load-use hazards: the 2-bit counter must stop at 3
        for (int n = 0; n < 5; n++) begin
            run_row(mkv(ins(5'd1, 5'd0, 5'd5, 32'h300, 0, 32'd12, C_LW, 2'b00), 1'b1, 1'b1, K_LOAD, 32'h300, 0, 16'(n), 0));
            run_row(mkv(ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10), 1'b1, 1'b0, K_BUB, 0, 0, 16'(n + 1), 0));
            check("s_stall_cnt", row_idx, 128'(s_stall_cnt), 128'((n + 1 > 3) ? 3 : n + 1));
            run_row(mkv(ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10), 1'b1, 1'b1, K_LOAD, 32'h7, 32'h8, 16'(n + 1), 0));
        end

        // Four flushes: the 2-bit flush counter must stop at 3
        for (int k = 0; k < 4; k++) begin
            t = ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_ADD, 2'b10); t.flush = 1'b1;
            run_row(mkv(t, 1'b1, 1'b1, K_BUB, 0, 0, 16'd5, 16'(k + 1)));
            check("s_flush_cnt", row_idx, 128'(s_flush_cnt), 128'((k + 1 > 3) ? 3 : k + 1));
        end

        // Hold with flush pending keeps everything, saturated counters included
        t = ins(5'd5, 5'd2, 5'd8, 32'h7, 32'h8, 0, C_LW, 2'b10); t.hold = 1'b1; t.flush = 1'b1;
        run_row(mkv(t, 1'b1, 1'b1, K_KEEP, 0, 0, 16'd5, 16'd4));
        check("s_stall_hold", row_idx, 128'(s_stall_cnt), 128'(3));
        check("s_flush_hold", row_idx, 128'(s_flush_cnt), 128'(3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
